// File: rtl/counter_pkg.sv
// Shared definitions for the BCD speed counter slice.
//   speed_e    : speed state encoding, PAUSED plus up to seven running levels
//   MAX_DIGITS : largest supported number of BCD digits
//   SEG_OFF    : active-low segment pattern with every segment dark
package counter_pkg;

  typedef enum logic [2:0] {
    PAUSED = 3'd0,
    S1     = 3'd1,
    S2     = 3'd2,
    S3     = 3'd3,
    S4     = 3'd4,
    S5     = 3'd5,
    S6     = 3'd6,
    S7     = 3'd7
  } speed_e;

  localparam int         MAX_DIGITS = 8;
  localparam logic [6:0] SEG_OFF    = 7'h7F;

endpackage

// File: rtl/hex_decoder.sv
// Single-digit BCD to seven-segment decoder, active-low outputs.
//   digit : BCD digit value (values above 9 blank the display)
//   seg   : segments {g,f,e,d,c,b,a}, 0 = lit
module hex_decoder
  import counter_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (digit)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/bcd_speed_counter.sv
// Multi-digit BCD up/down counter whose count rate is stepped by two keys.
//   clk, reset_n     : system clock, asynchronous active-low reset
//   key_up_n         : raw active-low speed-up key (asynchronous)
//   key_down_n       : raw active-low speed-down key (asynchronous)
//   dir              : 1 = count up, 0 = count down
//   clear            : synchronous count clear, wins over tick
//   speed            : current speed level, 0 = paused
//   tick             : one-cycle count-enable pulse
//   wrap             : one-cycle pulse when the count wraps around
//   bcd              : count value, units digit in bits [3:0]
//   seg              : active-low segments per digit, units digit in bits [6:0]
module bcd_speed_counter
  import counter_pkg::*;
#(
  parameter int NUM_DIGITS = 2,
  parameter int NUM_SPEEDS = 3,
  parameter int TICK_DIV   = 50_000_000
)(
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    key_up_n,
  input  logic                    key_down_n,
  input  logic                    dir,
  input  logic                    clear,
  output logic [2:0]              speed,
  output logic                    tick,
  output logic                    wrap,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic [7*NUM_DIGITS-1:0] seg
);

  localparam int DIV_W = $clog2(TICK_DIV + 1);
  localparam int BCD_W = 4 * NUM_DIGITS;

  // One step of the speed state machine, saturating at both ends.
  // Simultaneous up and down requests cancel.
  function automatic logic [2:0] step_speed(input logic [2:0] cur,
                                            input logic       inc,
                                            input logic       dec);
    logic [2:0] nxt;
    nxt = cur;
    if (inc && !dec && (cur < 3'(NUM_SPEEDS)))
      nxt = cur + 3'd1;
    else if (dec && !inc && (cur != PAUSED))
      nxt = cur - 3'd1;
    return nxt;
  endfunction

  // BCD increment/decrement across all digits; MSB of the result is the
  // carry/borrow out of the top digit, i.e. the wrap flag.
  function automatic logic [BCD_W:0] bcd_step(input logic [BCD_W-1:0] cur,
                                              input logic             up);
    logic [BCD_W-1:0] nxt;
    logic [3:0]       d;
    logic             cy;
    nxt = cur;
    cy  = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      d = cur[4*i +: 4];
      if (cy) begin
        if (up) begin
          if (d == 4'd9) begin
            nxt[4*i +: 4] = 4'd0;
          end else begin
            nxt[4*i +: 4] = d + 4'd1;
            cy = 1'b0;
          end
        end else begin
          if (d == 4'd0) begin
            nxt[4*i +: 4] = 4'd9;
          end else begin
            nxt[4*i +: 4] = d - 4'd1;
            cy = 1'b0;
          end
        end
      end
    end
    return {cy, nxt};
  endfunction

  // Stage p0/p1: two-flop synchronisers; p2 holds the previous synchronised
  // level for falling-edge detection. All reset to 1 (key released).
  logic       up_p0, up_p1, up_p2;
  logic       dn_p0, dn_p1, dn_p2;
  logic [1:0] flush_q;
  logic       up_arm, dn_arm;
  logic       up_press, dn_press;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      up_p0   <= 1'b1;
      up_p1   <= 1'b1;
      up_p2   <= 1'b1;
      dn_p0   <= 1'b1;
      dn_p1   <= 1'b1;
      dn_p2   <= 1'b1;
      flush_q <= 2'd0;
      up_arm  <= 1'b0;
      dn_arm  <= 1'b0;
    end else begin
      up_p0 <= key_up_n;
      up_p1 <= up_p0;
      up_p2 <= up_p1;
      dn_p0 <= key_down_n;
      dn_p1 <= dn_p0;
      dn_p2 <= dn_p1;
      if (!flush_q[1])
        flush_q <= flush_q + 2'd1;
      // The chains show "released" for two cycles after reset regardless of
      // the pin, so a key only arms once a real released level has been seen.
      up_arm <= up_arm | (flush_q[1] & up_p1);
      dn_arm <= dn_arm | (flush_q[1] & dn_p1);
    end
  end

  assign up_press = up_arm & up_p2 & ~up_p1;
  assign dn_press = dn_arm & dn_p2 & ~dn_p1;

  // Speed state and tick divider
  logic [2:0]       speed_q;
  logic [2:0]       speed_nxt;
  logic             speed_chg;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] period;
  logic             tick_q;

  assign speed_nxt = step_speed(speed_q, up_press, dn_press);
  assign speed_chg = (speed_nxt != speed_q);
  assign period    = DIV_W'(TICK_DIV) >> (speed_q - 3'd1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      speed_q <= PAUSED;
      div_q   <= '0;
      tick_q  <= 1'b0;
    end else begin
      speed_q <= speed_nxt;
      // A speed change restarts the period from zero at the new rate.
      if (speed_chg || (speed_q == PAUSED)) begin
        div_q  <= '0;
        tick_q <= 1'b0;
      end else if (div_q == (period - DIV_W'(1))) begin
        div_q  <= '0;
        tick_q <= 1'b1;
      end else begin
        div_q  <= div_q + DIV_W'(1);
        tick_q <= 1'b0;
      end
    end
  end

  // Count register, updated in the cycle after tick
  logic [BCD_W-1:0] bcd_q;
  logic [BCD_W:0]   bcd_nxt;
  logic             wrap_q;

  assign bcd_nxt = bcd_step(bcd_q, dir);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bcd_q  <= '0;
      wrap_q <= 1'b0;
    end else if (clear) begin
      bcd_q  <= '0;
      wrap_q <= 1'b0;
    end else if (tick_q) begin
      bcd_q  <= bcd_nxt[BCD_W-1:0];
      wrap_q <= bcd_nxt[BCD_W];
    end else begin
      wrap_q <= 1'b0;
    end
  end

  assign speed = speed_q;
  assign tick  = tick_q;
  assign wrap  = wrap_q;
  assign bcd   = bcd_q;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    hex_decoder u_dec (
      .digit (bcd_q[4*g +: 4]),
      .seg   (seg[7*g +: 7])
    );
  end

endmodule

// File: doc/bcd_speed_counter.md
BCD_SPEED_COUNTER -- requirements
Module: bcd_speed_counter

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 2: number of BCD digits, 1..8.
REQ-002 SHALL have parameter NUM_SPEEDS, default 3: number of running speed levels, 1..7.
REQ-003 SHALL have parameter TICK_DIV, default 50_000_000: clock cycles per tick at speed 1, at least 2^NUM_SPEEDS.
REQ-004 SHALL have port clk, input, 1: single system clock.
REQ-005 SHALL have port reset_n, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port key_up_n, input, 1: raw active-low speed-up key, asynchronous to clk.
REQ-007 SHALL have port key_down_n, input, 1: raw active-low speed-down key, asynchronous to clk.
REQ-008 SHALL have port dir, input, 1: count direction, 1 = up, 0 = down; synchronous to clk.
REQ-009 SHALL have port clear, input, 1: synchronous count clear.
REQ-010 SHALL have port speed, output, 3: current speed level, 0 = paused.
REQ-011 SHALL have port tick, output, 1: one-cycle count-enable pulse.
REQ-012 SHALL have port wrap, output, 1: one-cycle pulse on count wrap-around.
REQ-013 SHALL have port bcd, output, 4*NUM_DIGITS: count value, digit 0 (units) in bits [3:0].
REQ-014 SHALL have port seg, output, 7*NUM_DIGITS: active-low segments {g..a}, digit 0 in bits [6:0].

Function
REQ-015 SHALL pass each key through a 2-flop synchroniser and flag a press on the synchronised 1->0 transition, one cycle wide, 3 cycles after the raw edge at most.
REQ-016 SHALL implement a speed state machine with states PAUSED(0), S1 .. S<NUM_SPEEDS>.
REQ-017 SHALL move the speed state +1 on an up press and -1 on a down press, saturating at NUM_SPEEDS and at 0.
REQ-018 SHALL ignore up and down presses that land in the same cycle.
REQ-019 SHALL set the tick period at speed s>0 to TICK_DIV >> (s-1) cycles.
REQ-020 SHALL hold the divider at 0 and never assert tick while PAUSED.
REQ-021 SHALL reload the divider to 0 in the cycle after any speed change, so the first tick at the new speed arrives one full new period later.
REQ-022 SHALL assert tick for one cycle when the divider equals period-1, with the divider returning to 0.
REQ-023 SHALL update bcd in the cycle after tick by +1 when dir=1 and -1 when dir=0, with BCD carry/borrow across all digits.
REQ-024 SHALL wrap up-counting from all-9s to 0 and down-counting from 0 to all-9s, asserting wrap for the same cycle that bcd updates.
REQ-025 SHALL give clear priority over tick: on clear, bcd becomes 0 next cycle, wrap stays 0, and speed and divider are unaffected.
REQ-026 SHALL take seg as a combinational decode of bcd, producing all segments off (7'h7F) for any digit value above 9.
REQ-027 SHALL hold every digit in 0..9 in all reachable states.

Reset
REQ-028 SHALL asynchronously clear, while reset_n=0, the speed state to PAUSED, the divider, bcd, tick and wrap to 0, and the synchronisers to 1 (keys released).
REQ-029 SHALL generate no press event from keys held low across reset deassertion until they are released and pressed again.
REQ-030 SHALL abandon a tick period in progress when reset asserts mid-period, with no partial tick after release.

Structure
REQ-031 SHALL place the speed state enum, MAX_DIGITS=8 and the segment-off constant in a shared package, counter_pkg.
REQ-032 SHALL instantiate one hex_decoder sub-module per digit through a generate loop; synchroniser, edge detection, speed FSM, divider and BCD chain stay in this module.

Verification (NUM_DIGITS=2, NUM_SPEEDS=3, TICK_DIV=16)
REQ-033 SHALL check that after reset, 1 up press gives speed=1, with ticks 16 cycles apart and bcd 00->01->02.
REQ-034 SHALL check that 5 up presses saturate speed at 3 (period 4), and that 4 down presses give speed=0 with no further ticks and bcd frozen.
REQ-035 SHALL check that dir=1 with bcd=99 and one tick gives bcd=00 and wrap=1 for one cycle, and that dir=0 with bcd=00 and one tick gives bcd=99 and wrap=1.
REQ-036 SHALL check that with dir=1 and bcd=09, one tick gives bcd=10, and that with dir=0 and bcd=10, one tick gives bcd=09.
REQ-037 SHALL check that up and down presses in the same cycle leave speed unchanged, and that clear coinciding with tick gives bcd=00 and wrap=0.
REQ-038 SHALL check that reset asserted mid-period with key_up_n held low gives speed=0 and bcd=00, with no press event until the key is released and pressed again.
